// File: rtl/spike_step_sched_pkg.sv
// rtl/spike_step_sched_pkg.sv - shared state encodings and encoder frame length for the spike timestep scheduler
package spike_step_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ENC,
    S_WAIT_LAYER,
    S_NEXT,
    S_DONE
  } state_e;

  localparam int ENC_FRAME_LEN = 144;

endpackage

// File: rtl/spike_step_sched.sv
// rtl/spike_step_sched.sv - issues N run frames then R rest frames to the LFSR spike encoder
// Optional per-frame watchdog enabled by defining STEP_TIMEOUT_EN.
module spike_step_sched
  import spike_step_sched_pkg::*;
#(
  parameter int STEP_W  = 8,
  parameter int TO_W    = 12,
  parameter int TIMEOUT = 4000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic [STEP_W-1:0] i_num_steps,
  input  logic [STEP_W-1:0] i_rest_steps,
  input  logic              i_enc_valid,
  input  logic              i_layer_done,
  output logic              o_run,
  output logic              o_rest_run,
  output logic [STEP_W:0]   o_step_idx,
  output logic              o_rest_phase,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  state_e              state_q, state_d;
  logic [STEP_W:0]     step_idx_q, step_idx_d;
  logic [STEP_W-1:0]   n_q, n_d;
  logic [STEP_W:0]     total_q, total_d;
  logic                phase_q, phase_d;
  logic                seen_rise_q, seen_rise_d;
  logic                layer_flag_q, layer_flag_d;
  logic                err_q, err_d;
  logic                timeout;
  logic [STEP_W:0]     start_total;

  assign start_total = {1'b0, i_num_steps} + {1'b0, i_rest_steps};

`ifdef STEP_TIMEOUT_EN
  logic [TO_W-1:0] wdog_q, wdog_d;

  // Saturating counter; value k means k cycles have elapsed since LAUNCH.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == S_LAUNCH) begin
      wdog_d = TO_W'(1);
    end else if ((state_q == S_WAIT_ENC || state_q == S_WAIT_LAYER) && (wdog_q != '1)) begin
      wdog_d = wdog_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wdog_q <= '0;
    else          wdog_q <= wdog_d;
  end

  assign timeout = (wdog_q >= TO_W'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    step_idx_d   = step_idx_q;
    n_d          = n_q;
    total_d      = total_q;
    phase_d      = phase_q;
    seen_rise_d  = seen_rise_q;
    layer_flag_d = layer_flag_q;
    err_d        = err_q;
    o_run        = 1'b0;
    o_rest_run   = 1'b0;
    o_done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          n_d        = i_num_steps;
          total_d    = start_total;
          step_idx_d = '0;
          err_d      = 1'b0;
          if (start_total == '0) begin
            state_d = S_DONE;
            phase_d = 1'b0;
          end else begin
            state_d = S_LAUNCH;
            phase_d = (i_num_steps == '0);
          end
        end
      end
      S_LAUNCH: begin
        if (step_idx_q < {1'b0, n_q}) o_run      = 1'b1;
        else                          o_rest_run = 1'b1;
        seen_rise_d  = 1'b0;
        layer_flag_d = i_layer_done;
        state_d      = S_WAIT_ENC;
      end
      S_WAIT_ENC: begin
        seen_rise_d = seen_rise_q | i_enc_valid;
        if (i_layer_done) layer_flag_d = 1'b1;
        if (seen_rise_q && !i_enc_valid) state_d = S_WAIT_LAYER;
        if (timeout) begin
          state_d = S_DONE;
          phase_d = 1'b0;
          err_d   = 1'b1;
        end
      end
      S_WAIT_LAYER: begin
        if (i_layer_done) layer_flag_d = 1'b1;
        if (layer_flag_q || i_layer_done) state_d = S_NEXT;
        if (timeout) begin
          state_d = S_DONE;
          phase_d = 1'b0;
          err_d   = 1'b1;
        end
      end
      S_NEXT: begin
        step_idx_d = step_idx_q + 1'b1;
        if (step_idx_d == total_q) begin
          state_d = S_DONE;
          phase_d = 1'b0;
        end else begin
          state_d = S_LAUNCH;
          phase_d = (step_idx_d >= {1'b0, n_q});
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      step_idx_q   <= '0;
      n_q          <= '0;
      total_q      <= '0;
      phase_q      <= 1'b0;
      seen_rise_q  <= 1'b0;
      layer_flag_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_idx_q   <= step_idx_d;
      n_q          <= n_d;
      total_q      <= total_d;
      phase_q      <= phase_d;
      seen_rise_q  <= seen_rise_d;
      layer_flag_q <= layer_flag_d;
      err_q        <= err_d;
    end
  end

  assign o_step_idx   = step_idx_q;
  assign o_rest_phase = phase_q;
  assign o_busy       = (state_q != S_IDLE);
`ifdef STEP_TIMEOUT_EN
  assign o_err        = err_q;
`else
  assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_spike_step_sched.sv
// tb/tb_spike_step_sched.sv - directed self-checking bench for spike_step_sched (timeout test under STEP_TIMEOUT_EN)
module tb_spike_step_sched;
  import spike_step_sched_pkg::*;

`ifdef STEP_TIMEOUT_EN
  localparam int TB_TIMEOUT = 300;
`else
  localparam int TB_TIMEOUT = 4000;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_num_steps = '0;
  logic [7:0] i_rest_steps = '0;
  logic       i_enc_valid = 1'b0;
  logic       i_layer_done = 1'b0;
  logic       o_run, o_rest_run, o_rest_phase, o_busy, o_done, o_err;
  logic [8:0] o_step_idx;

  spike_step_sched #(.STEP_W(8), .TO_W(12), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_num_steps(i_num_steps),
    .i_rest_steps(i_rest_steps), .i_enc_valid(i_enc_valid), .i_layer_done(i_layer_done),
    .o_run(o_run), .o_rest_run(o_rest_run), .o_step_idx(o_step_idx),
    .o_rest_phase(o_rest_phase), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Encoder / layer responder: 0 = layer_done layer_delay cycles after valid fall,
  // 1 = layer_done in the middle of the valid window, 2 = layer_done withheld.
  int enc_len = ENC_FRAME_LEN;
  int layer_delay = 5;
  int layer_mode = 0;
  int enc_cnt = 0;
  int lay_cnt = -1;
  bit pend = 0;

  always begin
    @(posedge clk);
    #1;
    i_layer_done = 1'b0;
    if (!reset_n) begin
      enc_cnt = 0; lay_cnt = -1; pend = 0; i_enc_valid = 1'b0;
    end else begin
      if (pend) begin
        pend = 0; i_enc_valid = 1'b1; enc_cnt = enc_len;
        if (layer_mode == 1) lay_cnt = enc_len / 2;
      end else if (enc_cnt > 0) begin
        enc_cnt--;
        if (enc_cnt == 0) begin
          i_enc_valid = 1'b0;
          if (layer_mode == 0) lay_cnt = layer_delay;
        end
      end
      if (lay_cnt == 0) begin i_layer_done = 1'b1; lay_cnt = -1; end
      else if (lay_cnt > 0) lay_cnt--;
      if (o_run || o_rest_run) pend = 1;
    end
  end

  // Monitor
  int idx_log[$];
  int kind_log[$];
  int ph_log[$];
  int launch_log[$];
  int run_cnt, rest_cnt, done_cnt, both_cnt, bad_ph, done_cyc, fall_cyc, last_gap, cur_n;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (o_run || o_rest_run) begin
        idx_log.push_back(int'(o_step_idx));
        kind_log.push_back(int'(o_rest_run));
        ph_log.push_back(int'(o_rest_phase));
        launch_log.push_back(cyc);
        last_gap = cyc - fall_cyc;
      end
      if (o_run) run_cnt++;
      if (o_rest_run) rest_cnt++;
      if (o_run && o_rest_run) both_cnt++;
      if (o_done) begin
        done_cnt++; done_cyc = cyc;
        if (o_rest_phase) bad_ph++;
      end
      if (o_rest_phase && int'(o_step_idx) < cur_n) bad_ph++;
      if (prev_valid && !i_enc_valid) fall_cyc = cyc;
    end
    prev_valid = i_enc_valid;
  end

  task automatic clear_logs(input int n);
    idx_log.delete(); kind_log.delete(); ph_log.delete(); launch_log.delete();
    run_cnt = 0; rest_cnt = 0; done_cnt = 0; both_cnt = 0; bad_ph = 0;
    done_cyc = -1; fall_cyc = 0; last_gap = -1; cur_n = n;
  endtask

  int start_cyc;
  task automatic do_start(input int n, input int r);
    @(posedge clk); #1;
    i_start = 1'b1; i_num_steps = 8'(n); i_rest_steps = 8'(r); start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    int k = 0;
    while (done_cnt == 0 && k < bound) begin @(posedge clk); #1; k++; end
    checks++;
    if (done_cnt == 0) begin
      errors++; $display("FAIL %s_done_wait: no o_done within %0d cycles", name, bound);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_run, o_rest_run, o_step_idx, o_rest_phase, o_busy, o_done, o_err} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got run=%b rest=%b idx=%0d ph=%b busy=%b done=%b err=%b want all 0",
               o_run, o_rest_run, o_step_idx, o_rest_phase, o_busy, o_done, o_err);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int exp_idx[5] = '{0, 1, 2, 3, 4};
    int exp_kind[5] = '{0, 0, 0, 1, 1};
    layer_mode = 0; layer_delay = 5; enc_len = ENC_FRAME_LEN;
    clear_logs(3);
    do_start(3, 2);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", o_busy); end
    wait_done(5000, "basic");
    checks++;
    if (run_cnt != 3 || rest_cnt != 2) begin
      errors++; $display("FAIL basic_counts: got run=%0d rest=%0d want 3 2", run_cnt, rest_cnt);
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    checks++;
    if (idx_log.size() != 5) begin
      errors++; $display("FAIL basic_launches: got %0d want 5", idx_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (idx_log[i] != exp_idx[i] || kind_log[i] != exp_kind[i] || ph_log[i] != exp_kind[i]) begin
          errors++;
          $display("FAIL basic_frame%0d: got idx=%0d rest=%0d phase=%0d want idx=%0d rest=%0d phase=%0d",
                   i, idx_log[i], kind_log[i], ph_log[i], exp_idx[i], exp_kind[i], exp_kind[i]);
        end
      end
    end
    checks++;
    if (bad_ph != 0 || both_cnt != 0) begin
      errors++; $display("FAIL basic_phase: got bad_phase=%0d both=%0d want 0 0", bad_ph, both_cnt);
    end
    checks++;
    if (last_gap != 7) begin errors++; $display("FAIL basic_fall_to_launch: got %0d want 7", last_gap); end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_idle_after: got busy=%b want 0", o_busy); end
  endtask

  task automatic test_zero();
    clear_logs(0);
    do_start(0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 1 || done_cyc != start_cyc + 1) begin
      errors++; $display("FAIL zero_done: got count=%0d at +%0d want 1 at +1", done_cnt, done_cyc - start_cyc);
    end
    checks++;
    if (run_cnt + rest_cnt != 0) begin
      errors++; $display("FAIL zero_pulses: got %0d want 0", run_cnt + rest_cnt);
    end
  endtask

  task automatic test_early_layer();
    layer_mode = 1; enc_len = ENC_FRAME_LEN;
    clear_logs(2);
    do_start(2, 0);
    wait_done(2000, "early");
    checks++;
    if (run_cnt != 2 || last_gap != 3) begin
      errors++; $display("FAIL early_layer: got runs=%0d gap=%0d want 2 3", run_cnt, last_gap);
    end
    layer_mode = 0;
  endtask

  task automatic test_start_busy();
    clear_logs(2);
    do_start(2, 0);
    repeat (20) @(posedge clk);
    #1;
    i_start = 1'b1; i_num_steps = 8'd5; i_rest_steps = 8'd3;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_done(2000, "busy");
    checks++;
    if (run_cnt != 2 || rest_cnt != 0 || done_cnt != 1) begin
      errors++; $display("FAIL start_busy: got run=%0d rest=%0d done=%0d want 2 0 1", run_cnt, rest_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clear_logs(3);
    do_start(3, 0);
    while (!(o_step_idx == 9'd1 && i_enc_valid) && k < 1000) begin @(posedge clk); #1; k++; end
    checks++;
    if (k >= 1000) begin errors++; $display("FAIL reset_mid_reach: frame 1 not reached in %0d cycles", k); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({o_run, o_rest_run, o_step_idx, o_rest_phase, o_busy, o_done, o_err} !== 15'd0) begin
      errors++; $display("FAIL reset_mid_outputs: got idx=%0d busy=%b want all 0", o_step_idx, o_busy);
    end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL reset_mid_nodone: got %0d want 0", done_cnt); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_logs(1);
    do_start(1, 1);
    wait_done(2000, "restart");
    checks++;
    if (run_cnt != 1 || rest_cnt != 1 || done_cnt != 1) begin
      errors++; $display("FAIL reset_restart: got run=%0d rest=%0d done=%0d want 1 1 1", run_cnt, rest_cnt, done_cnt);
    end
  endtask

  task automatic test_max_counts();
    enc_len = 4; layer_delay = 1; layer_mode = 0;
    clear_logs(255);
    do_start(255, 255);
    wait_done(10000, "max");
    checks++;
    if (run_cnt != 255 || rest_cnt != 255 || idx_log.size() != 510) begin
      errors++; $display("FAIL max_counts: got run=%0d rest=%0d launches=%0d want 255 255 510",
                         run_cnt, rest_cnt, idx_log.size());
    end else if (idx_log[509] != 509 || idx_log[255] != 255 || kind_log[255] != 1 || kind_log[254] != 0) begin
      errors++; $display("FAIL max_index: got last=%0d first_rest=%0d want 509 255", idx_log[509], idx_log[255]);
    end
    checks++;
    if (bad_ph != 0 || done_cnt != 1) begin
      errors++; $display("FAIL max_phase_done: got bad=%0d done=%0d want 0 1", bad_ph, done_cnt);
    end
    enc_len = ENC_FRAME_LEN; layer_delay = 5;
  endtask

`ifdef STEP_TIMEOUT_EN
  task automatic test_timeout();
    layer_mode = 2;
    clear_logs(2);
    do_start(2, 0);
    wait_done(1000, "timeout");
    checks++;
    if (launch_log.size() != 1 || done_cyc - launch_log[0] != 300) begin
      errors++; $display("FAIL timeout_latency: got launches=%0d delta=%0d want 1 300",
                         launch_log.size(), done_cyc - (launch_log.size() > 0 ? launch_log[0] : 0));
    end
    checks++;
    if (o_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", o_err); end
    layer_mode = 0;
    clear_logs(1);
    do_start(1, 0);
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear: got %b want 0", o_err); end
    wait_done(2000, "after_timeout");
  endtask
`endif

  initial begin
    clear_logs(0);
    test_reset();
    test_basic();
    test_zero();
    test_early_layer();
    test_start_busy();
    test_reset_mid();
    test_max_counts();
`ifdef STEP_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
